adder_operand_sequencer: RTL and testbench

//  Upstream stage for four_bit_adder. It loads operands a and b one after the

---
 rtl/adder_operand_sequencer.sv | 116 +++++++++++
 tb/tb_adder_operand_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for a combinational adder. Button presses load operand A and
// then operand B. After a settle interval it captures {cout,s} and checks it against a+b.
module adder_operand_sequencer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             mismatch,
  output logic             busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH:0]     result_q, result_d;
  logic               valid_q, valid_d;
  logic               mismatch_q, mismatch_d;
  logic               press;
  logic [WIDTH:0]     sum_ref;
  logic [WIDTH:0]     captured;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] is the edge-detect history.
  assign press    = sync_q[1] & ~sync_q[2];
  assign sum_ref  = {1'b0, a_q} + {1'b0, b_q};
  assign captured = {cout, s};

  always_comb begin
    // NOTE: every _d starts at its current _q so that no path leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    valid_d    = valid_q;
    mismatch_d = mismatch_q;
    case (state_q)
      LOAD_A: if (press) begin
        a_d     = sw;
        state_d = LOAD_B;
      end
      LOAD_B: if (press) begin
        b_d     = sw;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        // Presses are dropped here on purpose: only the edge-detect history remembers them.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          result_d   = captured;
          mismatch_d = (captured != sum_ref);
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: if (press) begin
        a_d        = sw;
        valid_d    = 1'b0;
        mismatch_d = 1'b0;
        state_d    = LOAD_B;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones would race with other clocked blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], btn};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign a            = a_q;
  assign b            = b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign mismatch     = mismatch_q;
  assign busy         = (state_q == SETTLE);

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer. A behavioural adder closes the loop.
// The adder's sum can be forced to zero so that the mismatch path can be exercised.
module tb_adder_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic [3:0] sw;
  logic [3:0] a, b, s;
  logic       cout;
  logic [4:0] result;
  logic       result_valid, mismatch, busy;
  logic       force_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {cout, s} = force_zero ? 5'd0 : ({1'b0, a} + {1'b0, b});

  adder_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
    .a(a), .b(b), .s(s), .cout(cout),
    .result(result), .result_valid(result_valid),
    .mismatch(mismatch), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press takes effect on the 3rd rising edge; returns at the falling edge after the next one.
  task automatic press(input logic [3:0] v);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  // Called right after a b-load press: one settle edge is behind us, capture on the 3rd from here.
  task automatic settle_check(input string tag, input logic [4:0] exp_res, input logic exp_mm);
    repeat (2) @(negedge clk);
    check({tag, "_busy"},      32'(busy), 1);
    check({tag, "_notvalid"},  32'(result_valid), 0);
    @(negedge clk);
    check({tag, "_valid"},     32'(result_valid), 1);
    check({tag, "_result"},    32'(result), 32'(exp_res));
    check({tag, "_mismatch"},  32'(mismatch), 32'(exp_mm));
    check({tag, "_idle"},      32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b0; sw = 4'd0; force_zero = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a", 32'(a), 0);
    check("rst_b", 32'(b), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 6 + 3 = 9
    press(4'b0110);
    check("t1_a", 32'(a), 6);
    check("t1_b_untouched", 32'(b), 0);
    press(4'b0011);
    check("t1_b", 32'(b), 3);
    settle_check("t1", 5'b01001, 1'b0);

    // 2: reload from DONE, 11 + 6 = 17 with carry
    press(4'b1011);
    check("t2_a", 32'(a), 11);
    check("t2_valid_drop", 32'(result_valid), 0);
    check("t2_result_kept", 32'(result), 9);
    press(4'b0110);
    settle_check("t2", 5'b10001, 1'b0);

    // 3: a held button gives exactly one press
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sw  = 4'd5;
    btn = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_a", 32'(a), 5);
    check("t3_b", 32'(b), 0);
    check("t3_state", 32'(dut.state_q), 1);
    btn = 1'b0;
    @(negedge clk);

    // 4: press during SETTLE is dropped, 5 + 7 = 12
    press(4'd7);
    sw  = 4'd9;
    btn = 1'b1;
    settle_check("t4", 5'd12, 1'b0);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_state_done", 32'(dut.state_q), 3);
    check("t4_a_kept", 32'(a), 5);
    check("t4_valid_kept", 32'(result_valid), 1);
    check("t4_result_kept", 32'(result), 12);

    // 5: reset mid-SETTLE aborts immediately, no capture later
    press(4'd1);
    press(4'd2);
    check("t5_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_a", 32'(a), 0);
    check("t5_b", 32'(b), 0);
    check("t5_result", 32'(result), 0);
    check("t5_valid", 32'(result_valid), 0);
    check("t5_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_state", 32'(dut.state_q), 0);
    check("t5_no_capture", 32'(result_valid), 0);
    check("t5_result_after", 32'(result), 0);

    // 6: broken adder output is flagged
    force_zero = 1'b1;
    press(4'd2);
    press(4'd3);
    settle_check("t6", 5'b00000, 1'b1);
    force_zero = 1'b0;

    // max operands: 15 + 15 = 30, mismatch clears on reload
    press(4'd15);
    check("t7_mismatch_clr", 32'(mismatch), 0);
    press(4'd15);
    settle_check("t7", 5'b11110, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
